// File: rtl/selector_secuencial_if.sv
// selector_secuencial_if: button/select bundle between a front panel and the selector
// Signals:
//   btn_next, btn_prev - raw asynchronous push-buttons
//   auto_en            - level enable for periodic automatic advance
//   ss                 - 4-bit select code for the downstream multiplexor
//   ss_chg             - one-cycle pulse in the cycle after ss changes
// Modports: master drives buttons/auto_en, slave (the selector) drives ss/ss_chg.
interface selector_secuencial_if;
  logic       btn_next;
  logic       btn_prev;
  logic       auto_en;
  logic [3:0] ss;
  logic       ss_chg;
  modport master (output btn_next, btn_prev, auto_en, input ss, ss_chg);
  modport slave  (input btn_next, btn_prev, auto_en, output ss, ss_chg);
endinterface

// File: rtl/selector_secuencial.sv
// selector_secuencial: debounced next/prev select counter with optional periodic auto-scan
// Ports:
//   clk    - sole clock, rising edge
//   rst    - asynchronous active-high reset
//   sel_if - selector_secuencial_if.slave (btn_next, btn_prev, auto_en in; ss, ss_chg out)
// Build option: define SELECTOR_AUTO_SCAN_EN to include the scan timer; otherwise
// auto_en is ignored and ss moves only on button presses.
module selector_secuencial #(
  parameter int N_SEL       = 10,
  parameter int DEB_CYCLES  = 4,
  parameter int SCAN_PERIOD = 8
) (
  input logic            clk,
  input logic            rst,
  selector_secuencial_if.slave sel_if
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  // index 0 = next, index 1 = prev
  logic [1:0]    raw, s1_q, s2_q, stb_q, ev_q;
  logic [CW-1:0] cnt_q [2];
  logic [3:0]    ss_q, ss_d, ss_inc, ss_dec;
  logic          ss_chg_q, nxt, prv, fire, up, dn;
  assign raw = {sel_if.btn_prev, sel_if.btn_next};
  assign nxt = ev_q[0];
  assign prv = ev_q[1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stb_q    <= '0;
      ev_q     <= '0;
      ss_q     <= '0;
      ss_chg_q <= 1'b0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      // ev_q pulses on the edge the stable level rises; ss reacts one edge later
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == stb_q[i]) begin
          cnt_q[i] <= '0;
          ev_q[i]  <= 1'b0;
        end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
          cnt_q[i] <= '0;
          stb_q[i] <= s2_q[i];
          ev_q[i]  <= s2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
          ev_q[i]  <= 1'b0;
        end
      end
      ss_q     <= ss_d;
      ss_chg_q <= ss_d != ss_q;
    end
  end
`ifdef SELECTOR_AUTO_SCAN_EN
  localparam int TW = $clog2(SCAN_PERIOD + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  assign fire  = sel_if.auto_en && tmr_q == TW'(SCAN_PERIOD - 1);
  // any button event restarts the scan period
  assign tmr_d = (!sel_if.auto_en || nxt || prv || fire) ? '0 : tmr_q + TW'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end
`else
  assign fire = sel_if.auto_en & 1'b0;
`endif
  always_comb begin
    ss_inc = ss_q == 4'(N_SEL - 1) ? 4'd0 : ss_q + 4'd1;
    ss_dec = ss_q == 4'd0 ? 4'(N_SEL - 1) : ss_q - 4'd1;
    // buttons win over the scan timer; simultaneous next+prev cancel
    up     = (nxt & ~prv) | (fire & ~nxt & ~prv);
    dn     = prv & ~nxt;
    ss_d   = up ? ss_inc : dn ? ss_dec : ss_q;
  end
  assign sel_if.ss     = ss_q;
  assign sel_if.ss_chg = ss_chg_q;
endmodule

// File: tb/tb_selector_secuencial.sv
// tb_selector_secuencial: directed + random stimulus against a window-based reference model
module tb_selector_secuencial;
  localparam int N = 10, DEB = 4, SP = 8;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, failures = 0;
  int ss_m, tm;
  bit chg_m;
  bit stb_m [2];
  bit ev_m [2];
  bit qn[$], qp[$];
  always #5 clk = ~clk;
  selector_secuencial_if bus();
  selector_secuencial #(.N_SEL(N), .DEB_CYCLES(DEB), .SCAN_PERIOD(SP)) dut (
    .clk(clk), .rst(rst), .sel_if(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // stable level flips once the last DEB synchronized samples all disagree with it
  function automatic bit all_ne(input bit qq[$], input bit s);
    for (int k = 1; k <= DEB; k++) if (qq[qq.size() - 1 - k] == s) return 1'b0;
    return 1'b1;
  endfunction
  task automatic model_reset();
    ss_m = 0; chg_m = 0; tm = 0;
    stb_m = '{0, 0}; ev_m = '{0, 0};
    qn.delete(); qp.delete();
    for (int k = 0; k < DEB + 2; k++) begin qn.push_back(1'b0); qp.push_back(1'b0); end
  endtask
  task automatic model_edge();
    bit auto_eff, fire, up, dn;
    int nss;
`ifdef SELECTOR_AUTO_SCAN_EN
    auto_eff = bus.auto_en;
`else
    auto_eff = 1'b0;
`endif
    fire = auto_eff && tm == SP - 1;
    up = (ev_m[0] && !ev_m[1]) || (fire && !ev_m[0] && !ev_m[1]);
    dn = ev_m[1] && !ev_m[0];
    nss = up ? (ss_m + 1) % N : dn ? (ss_m + N - 1) % N : ss_m;
    chg_m = nss != ss_m;
    ss_m = nss;
    tm = (!auto_eff || ev_m[0] || ev_m[1] || fire) ? 0 : tm + 1;
    ev_m[0] = 1'b0;
    ev_m[1] = 1'b0;
    if (all_ne(qn, stb_m[0])) begin stb_m[0] = !stb_m[0]; ev_m[0] = stb_m[0]; end
    if (all_ne(qp, stb_m[1])) begin stb_m[1] = !stb_m[1]; ev_m[1] = stb_m[1]; end
    qn.push_back(bus.btn_next); qp.push_back(bus.btn_prev);
    if (qn.size() > DEB + 2) begin void'(qn.pop_front()); void'(qp.pop_front()); end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ss", bus.ss, ss_m);
    chk("ss_chg", bus.ss_chg, chg_m);
    chk("ss_range", bus.ss < N, 1);
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1;
    chk("rst_ss", bus.ss, 0);
    chk("rst_chg", bus.ss_chg, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic press(input bit is_next);
    if (is_next) bus.btn_next = 1'b1; else bus.btn_prev = 1'b1;
    ticks(10);
    bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
    ticks(8);
  endtask
  initial begin
    bus.btn_next = 1'b0; bus.btn_prev = 1'b0; bus.auto_en = 1'b0;
    model_reset();
    #3;
    chk("init_ss", bus.ss, 0);
    chk("init_chg", bus.ss_chg, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    // latency: raise after edge 0, ss updates on edge 7, ss_chg for one cycle
    bus.btn_next = 1'b1;
    ticks(6);
    chk("lat_before", bus.ss, 0);
    tick();
    chk("lat_ss", bus.ss, 1);
    chk("lat_chg", bus.ss_chg, 1);
    tick();
    chk("lat_chg_off", bus.ss_chg, 0);
    bus.btn_next = 1'b0;
    ticks(10);
    chk("release_no_ev", bus.ss, 1);
    // wrap both ways
    press(1'b0);
    chk("prev_to0", bus.ss, 0);
    press(1'b0);
    chk("wrap_prev", bus.ss, 9);
    press(1'b1);
    chk("wrap_next", bus.ss, 0);
    // simultaneous presses cancel
    bus.btn_next = 1'b1; bus.btn_prev = 1'b1;
    ticks(12);
    chk("both_ss", bus.ss, 0);
    bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
    ticks(8);
    // bounce, then a clean hold
    for (int k = 0; k < 10; k++) begin bus.btn_next = ~bus.btn_next; ticks(2); end
    chk("bounce_none", bus.ss, 0);
    bus.btn_next = 1'b1;
    ticks(6);
    chk("bounce_before", bus.ss, 0);
    tick();
    chk("bounce_one", bus.ss, 1);
    bus.btn_next = 1'b0;
    ticks(8);
    for (int k = 0; k < 4; k++) press(1'b1);
    chk("at5", bus.ss, 5);
    // reset mid-debounce discards the partial count
    bus.btn_next = 1'b1;
    ticks(4);
    pulse_rst();
    ticks(6);
    chk("rst_mid_hold", bus.ss, 0);
    tick();
    chk("rst_mid_after", bus.ss, 1);
    bus.btn_next = 1'b0;
    ticks(8);
    bus.auto_en = 1'b1;
    pulse_rst();
`ifdef SELECTOR_AUTO_SCAN_EN
    ticks(7);
    chk("scan_pre", bus.ss, 0);
    tick();
    chk("scan_first", bus.ss, 1);
    ticks(72);
    chk("scan_wrap", bus.ss, 0);
    pulse_rst();
    tick();
    bus.btn_next = 1'b1;
    ticks(7);
    chk("tc_press", bus.ss, 1);
    ticks(7);
    chk("tc_hold", bus.ss, 1);
    tick();
    chk("tc_next_auto", bus.ss, 2);
    bus.btn_next = 1'b0;
`else
    ticks(30);
    chk("noscan", bus.ss, 0);
`endif
    bus.auto_en = 1'b0;
    ticks(8);
    for (int s = 0; s < 40; s++) begin
      bus.btn_next = 1'($urandom_range(0, 1));
      bus.btn_prev = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) bus.auto_en = ~bus.auto_en;
      if ($urandom_range(0, 11) == 0) pulse_rst();
      ticks($urandom_range(1, 14));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/selector_secuencial.md
SELECTOR_SECUENCIAL -- requirements
Module: selector_secuencial

Interface
REQ-001 The module SHALL expose these parameters, one per line: name, default, meaning.
- N_SEL, 10, number of valid select codes (0..N_SEL-1); legal range 2..16.
- DEB_CYCLES, 4, consecutive stable cycles required to accept a button level change; minimum 1.
- SCAN_PERIOD, 8, clock cycles between automatic advances.

REQ-002 The module SHALL have these ports, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock; all state updates on its rising edge.
- rst, input, 1, asynchronous, active-high reset.
- btn_next, input, 1, raw asynchronous push-button; a press advances the select.
- btn_prev, input, 1, raw asynchronous push-button; a press retreats the select.
- auto_en, input, 1, level; 1 enables periodic automatic advance.
- ss, output, 4, select code driven to the downstream 10-way multiplexor.
- ss_chg, output, 1, one-cycle pulse in the cycle after ss changes.

Function
REQ-003 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-004 Each synchronized button SHALL have its own debounce counter; the stable level SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles, and any cycle of agreement SHALL clear the counter.
REQ-005 A press event SHALL be a 0->1 transition of the stable level; releases SHALL generate no event.
REQ-006 A next event alone SHALL set ss to ss+1, and N_SEL-1 SHALL wrap to 0.
REQ-007 A prev event alone SHALL set ss to ss-1, and 0 SHALL wrap to N_SEL-1.
REQ-008 Simultaneous next and prev events in the same cycle SHALL leave ss unchanged and SHALL NOT pulse ss_chg.
REQ-009 Latency from a raw button rising edge held steady to the ss update SHALL be exactly 2+DEB_CYCLES+1 rising edges of clk.
REQ-010 ss SHALL never hold a value of N_SEL or greater.
REQ-011 ss_chg SHALL be 1 for exactly one cycle, the cycle after each ss update, and 0 otherwise.
REQ-012 Scan timer: when auto_en=1, a timer SHALL count 0..SCAN_PERIOD-1; on reaching SCAN_PERIOD-1 it SHALL advance ss as in REQ-006 and restart at 0.
REQ-013 Any accepted button event SHALL restart the scan timer at 0 in the same edge, and a timer advance coinciding with a button event SHALL be suppressed, with the button taking priority.
REQ-014 When auto_en=0, the scan timer SHALL be held at 0.

Reset
REQ-015 Asserting rst SHALL immediately force ss=0, ss_chg=0, synchronizer flops=0, stable levels=0, debounce counters=0 and scan timer=0, independent of clk.
REQ-016 A button held during reset SHALL register as a press once rst deasserts, after the REQ-009 latency, because the stable level resets to 0.
REQ-017 Reset asserted mid-debounce or mid-scan SHALL discard the partial count, and no event SHALL be produced.

Configuration
REQ-018 The macro SELECTOR_AUTO_SCAN_EN SHALL gate the auto-scan feature.
REQ-019 With SELECTOR_AUTO_SCAN_EN defined, the scan timer and REQ-012 to REQ-014 SHALL be present.
REQ-020 With SELECTOR_AUTO_SCAN_EN undefined, the scan timer logic SHALL be omitted, auto_en SHALL remain a port but be ignored, and ss SHALL change only on button events.

Verification (defaults N_SEL=10, DEB_CYCLES=4, SCAN_PERIOD=8)
REQ-021 Scenario: after reset, btn_next held high from edge 0 -> ss goes 0->1 at edge 7, and ss_chg=1 during the following cycle only.
REQ-022 Scenario: ss=9, one clean next press -> ss=0; ss=0, one clean prev press -> ss=9.
REQ-023 Scenario: btn_next toggling every 2 cycles for 20 cycles (bounce), then held high -> exactly one increment, occurring 7 edges after the final rising edge.
REQ-024 Scenario: btn_next and btn_prev raised on the same edge and held -> ss unchanged and no ss_chg pulse.
REQ-025 Scenario (macro defined): auto_en=1 from reset for 80 cycles -> ss steps 0,1,...,9,0 every 8 cycles; a next press landing on the timer's terminal count gives a single increment, and the next auto step follows 8 cycles later.
REQ-026 Scenario: rst pulsed for 1 cycle with ss=5 and btn_next mid-debounce -> ss=0 immediately, and no increment occurs until the full latency elapses again.
